// File: rtl/ip_rx_cr_pkg.sv
// rtl/ip_rx_cr_pkg.sv - shared types and constants for the RX credit-return scheduler
package ip_rx_cr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ISSUE = 2'd2
    } pd_state_t;

    localparam int PH      = 0;
    localparam int PD      = 1;
    localparam int NPH     = 2;
    localparam int NPD     = 3;
    localparam int N_TYPES = 4;

endpackage

// File: rtl/ip_rx_cr_acc.sv
// rtl/ip_rx_cr_acc.sv - saturating pending-credit counter with sticky overflow
module ip_rx_cr_acc
    import ip_rx_cr_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int ADD_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADD_W-1:0] add,
    input  logic [ADD_W-1:0] sub,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovf
);

    // Wide enough that the raw add never wraps before the clamp test.
    localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] max_v;
    logic             sat;

    assign max_v = SUM_W'({CNT_W{1'b1}});

    // Adds and the issued amount apply together; sub never exceeds cnt.
    always_comb begin
        sum      = SUM_W'(cnt) + SUM_W'(add) - SUM_W'(sub);
        sat      = 1'b0;
        cnt_next = sum[CNT_W-1:0];
        if (sum > max_v) begin
            sat      = 1'b1;
            cnt_next = {CNT_W{1'b1}};
        end
    end

    // Counter register; overflow is sticky until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (sat) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_rx_cr_sched.sv
// rtl/ip_rx_cr_sched.sv - merges two requesters' credit releases and returns them to the core
module ip_rx_cr_sched
    import ip_rx_cr_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int PD_BURST  = 8,
    parameter int FLUSH_CYC = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       r0_ph,
    input  logic       r0_nph,
    input  logic       r0_npd,
    input  logic       r0_pd,
    input  logic [7:0] r0_pd_num,
    input  logic       r1_ph,
    input  logic       r1_nph,
    input  logic       r1_npd,
    input  logic       r1_pd,
    input  logic [7:0] r1_pd_num,
    input  logic       cr_en,
    output logic       ph_cr,
    output logic       nph_cr,
    output logic       npd_cr,
    output logic       pd_cr,
    output logic [7:0] pd_num,
    output logic       overflow,
    output logic       pend_empty
);

    localparam int TMR_W = $clog2(FLUSH_CYC + 1);

    logic [CNT_W-1:0]   ph_cnt, nph_cnt, npd_cnt, pd_cnt;
    logic [CNT_W-1:0]   ph_next, nph_next, npd_next, pd_next;
    logic [N_TYPES-1:0] ovf;
    logic               ph_iss, nph_iss, npd_iss;
    logic [7:0]         pd_iss;
    logic [8:0]         pd_add;
    pd_state_t          state, state_next;
    logic [TMR_W-1:0]   timer, timer_next;

    assign ph_iss  = cr_en && (ph_cnt != '0);
    assign nph_iss = cr_en && (nph_cnt != '0);
    assign npd_iss = cr_en && (npd_cnt != '0);
    assign pd_add  = {1'b0, (r0_pd ? r0_pd_num : 8'd0)} + {1'b0, (r1_pd ? r1_pd_num : 8'd0)};

    ip_rx_cr_acc #(.CNT_W(CNT_W), .ADD_W(2)) u_ph (
        .clk(clk), .rstn(rstn), .add({1'b0, r0_ph} + {1'b0, r1_ph}), .sub({1'b0, ph_iss}),
        .cnt(ph_cnt), .cnt_next(ph_next), .ovf(ovf[PH])
    );
    ip_rx_cr_acc #(.CNT_W(CNT_W), .ADD_W(2)) u_nph (
        .clk(clk), .rstn(rstn), .add({1'b0, r0_nph} + {1'b0, r1_nph}), .sub({1'b0, nph_iss}),
        .cnt(nph_cnt), .cnt_next(nph_next), .ovf(ovf[NPH])
    );
    ip_rx_cr_acc #(.CNT_W(CNT_W), .ADD_W(2)) u_npd (
        .clk(clk), .rstn(rstn), .add({1'b0, r0_npd} + {1'b0, r1_npd}), .sub({1'b0, npd_iss}),
        .cnt(npd_cnt), .cnt_next(npd_next), .ovf(ovf[NPD])
    );
    ip_rx_cr_acc #(.CNT_W(CNT_W), .ADD_W(9)) u_pd (
        .clk(clk), .rstn(rstn), .add(pd_add), .sub({1'b0, pd_iss}),
        .cnt(pd_cnt), .cnt_next(pd_next), .ovf(ovf[PD])
    );

    assign overflow = |ovf;

    // Posted-data burst size: up to PD_BURST credits, only while issuing and enabled.
    always_comb begin
        pd_iss = 8'd0;
        if (state == ISSUE && cr_en) begin
            pd_iss = (int'(pd_cnt) >= PD_BURST) ? 8'(PD_BURST) : 8'(pd_cnt);
        end
    end

    // Posted-data FSM next state, decided from the post-update pending count.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (int'(pd_next) >= PD_BURST) begin
                    state_next = ISSUE;
                end else if (pd_next != '0) begin
                    state_next = ACCUM;
                    timer_next = '0;
                end
            end
            ACCUM: begin
                // The flush timeout only releases the batch while returns are enabled.
                if (int'(pd_next) >= PD_BURST || (int'(timer) == FLUSH_CYC - 1 && cr_en)) begin
                    state_next = ISSUE;
                end else if (int'(timer) < FLUSH_CYC - 1) begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            ISSUE: begin
                if (cr_en) begin
                    if (pd_next == '0) begin
                        state_next = IDLE;
                    end else if (int'(pd_next) >= PD_BURST) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = ACCUM;
                        timer_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM, timer and registered return pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            timer      <= '0;
            ph_cr      <= 1'b0;
            nph_cr     <= 1'b0;
            npd_cr     <= 1'b0;
            pd_cr      <= 1'b0;
            pd_num     <= 8'd0;
            pend_empty <= 1'b1;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            ph_cr      <= ph_iss;
            nph_cr     <= nph_iss;
            npd_cr     <= npd_iss;
            pd_cr      <= (pd_iss != 8'd0);
            pd_num     <= pd_iss;
            pend_empty <= (ph_next == '0) && (nph_next == '0) && (npd_next == '0) && (pd_next == '0);
        end
    end

endmodule

// File: tb/tb_ip_rx_cr_sched.sv
// tb/tb_ip_rx_cr_sched.sv - self-checking bench for ip_rx_cr_sched
module tb_ip_rx_cr_sched;

    localparam int CNT_W     = 12;
    localparam int PD_BURST  = 8;
    localparam int FLUSH_CYC = 16;
    localparam int MAXV      = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_ACCUM = 1, M_ISSUE = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       r0_ph, r0_nph, r0_npd, r0_pd, r1_ph, r1_nph, r1_npd, r1_pd, cr_en;
    logic [7:0] r0_pd_num, r1_pd_num;
    logic       ph_cr, nph_cr, npd_cr, pd_cr, overflow, pend_empty;
    logic [7:0] pd_num;
    logic       ph_cr_s, nph_cr_s, npd_cr_s, pd_cr_s, overflow_s, pend_empty_s;
    logic [7:0] pd_num_s;

    int checks = 0;
    int errors = 0;

    int   m_ph, m_nph, m_npd, m_pd, m_mode, m_timer;
    logic m_ovf;
    logic e_ph, e_nph, e_npd, e_pd, e_empty;
    int   e_num;

    always #5 clk = ~clk;

    ip_rx_cr_sched #(.CNT_W(CNT_W), .PD_BURST(PD_BURST), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rstn(rstn),
        .r0_ph(r0_ph), .r0_nph(r0_nph), .r0_npd(r0_npd), .r0_pd(r0_pd), .r0_pd_num(r0_pd_num),
        .r1_ph(r1_ph), .r1_nph(r1_nph), .r1_npd(r1_npd), .r1_pd(r1_pd), .r1_pd_num(r1_pd_num),
        .cr_en(cr_en), .ph_cr(ph_cr), .nph_cr(nph_cr), .npd_cr(npd_cr), .pd_cr(pd_cr),
        .pd_num(pd_num), .overflow(overflow), .pend_empty(pend_empty)
    );

    ip_rx_cr_sched #(.CNT_W(4), .PD_BURST(PD_BURST), .FLUSH_CYC(FLUSH_CYC)) dut_s (
        .clk(clk), .rstn(rstn),
        .r0_ph(r0_ph), .r0_nph(r0_nph), .r0_npd(r0_npd), .r0_pd(r0_pd), .r0_pd_num(r0_pd_num),
        .r1_ph(r1_ph), .r1_nph(r1_nph), .r1_npd(r1_npd), .r1_pd(r1_pd), .r1_pd_num(r1_pd_num),
        .cr_en(cr_en), .ph_cr(ph_cr_s), .nph_cr(nph_cr_s), .npd_cr(npd_cr_s), .pd_cr(pd_cr_s),
        .pd_num(pd_num_s), .overflow(overflow_s), .pend_empty(pend_empty_s)
    );

    function automatic int clamp(input int v);
        if (v > MAXV) begin
            m_ovf = 1'b1;
            return MAXV;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_nph = 0; m_npd = 0; m_pd = 0; m_mode = M_IDLE; m_timer = 0; m_ovf = 1'b0;
        e_ph = 0; e_nph = 0; e_npd = 0; e_pd = 0; e_num = 0; e_empty = 1'b1;
    endtask

    // One clock edge of the reference: returns decided from the old counts, then counts updated.
    task automatic model_step();
        int a_pd, i_pd, n_pd;
        a_pd = (r0_pd ? int'(r0_pd_num) : 0) + (r1_pd ? int'(r1_pd_num) : 0);
        e_ph  = cr_en && (m_ph > 0);
        e_nph = cr_en && (m_nph > 0);
        e_npd = cr_en && (m_npd > 0);
        i_pd  = 0;
        if (m_mode == M_ISSUE && cr_en) i_pd = (m_pd < PD_BURST) ? m_pd : PD_BURST;
        m_ph  = clamp(m_ph + int'(r0_ph) + int'(r1_ph) - int'(e_ph));
        m_nph = clamp(m_nph + int'(r0_nph) + int'(r1_nph) - int'(e_nph));
        m_npd = clamp(m_npd + int'(r0_npd) + int'(r1_npd) - int'(e_npd));
        n_pd  = clamp(m_pd + a_pd - i_pd);
        case (m_mode)
            M_IDLE: begin
                if (n_pd >= PD_BURST) m_mode = M_ISSUE;
                else if (n_pd > 0) begin m_mode = M_ACCUM; m_timer = 0; end
            end
            M_ACCUM: begin
                if (n_pd >= PD_BURST || (m_timer == FLUSH_CYC - 1 && cr_en)) m_mode = M_ISSUE;
                else if (m_timer < FLUSH_CYC - 1) m_timer++;
            end
            default: begin
                if (cr_en) begin
                    if (n_pd == 0) m_mode = M_IDLE;
                    else if (n_pd < PD_BURST) begin m_mode = M_ACCUM; m_timer = 0; end
                end
            end
        endcase
        m_pd    = n_pd;
        e_pd    = (i_pd > 0);
        e_num   = i_pd;
        e_empty = (m_ph == 0) && (m_nph == 0) && (m_npd == 0) && (m_pd == 0);
    endtask

    task automatic clear_inputs();
        r0_ph = 0; r0_nph = 0; r0_npd = 0; r0_pd = 0; r0_pd_num = 8'd0;
        r1_ph = 0; r1_nph = 0; r1_npd = 0; r1_pd = 0; r1_pd_num = 8'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        cr_en = 1'b1;
        rstn  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ph_cr, nph_cr, npd_cr, pd_cr, pd_num, overflow, pend_empty} !== 14'b0000_00000000_01) begin
            errors++;
            $display("FAIL reset_main: got %b want 00000000000001",
                     {ph_cr, nph_cr, npd_cr, pd_cr, pd_num, overflow, pend_empty});
        end
        checks++;
        if ({ph_cr_s, nph_cr_s, npd_cr_s, pd_cr_s, pd_num_s, overflow_s, pend_empty_s} !== 14'b0000_00000000_01) begin
            errors++;
            $display("FAIL reset_small: got %b want 00000000000001",
                     {ph_cr_s, nph_cr_s, npd_cr_s, pd_cr_s, pd_num_s, overflow_s, pend_empty_s});
        end
    endtask

    task automatic test_ph_single();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (ph_cr !== (c == 2)) begin
                errors++;
                $display("FAIL ph_single cycle %0d: ph_cr=%b want %b", c, ph_cr, (c == 2));
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (pend_empty !== (c == 4)) begin
                    errors++;
                    $display("FAIL ph_single_empty cycle %0d: pend_empty=%b want %b", c, pend_empty, (c == 4));
                end
            end
            r0_ph = (c == 0);
            next_cycle();
        end
    endtask

    task automatic test_nph_dual();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (nph_cr !== (c == 2 || c == 3)) begin
                errors++;
                $display("FAIL nph_dual cycle %0d: nph_cr=%b want %b", c, nph_cr, (c == 2 || c == 3));
            end
            r0_nph = (c == 0);
            r1_nph = (c == 0);
            next_cycle();
        end
    endtask

    task automatic test_pd_burst();
        int want;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            want = (c == 2 || c == 3) ? 8 : (c == 20) ? 4 : 0;
            checks++;
            if ({pd_cr, pd_num} !== {want != 0, 8'(want)}) begin
                errors++;
                $display("FAIL pd_burst cycle %0d: pd_cr=%b pd_num=%0d want %b/%0d", c, pd_cr, pd_num, want != 0, want);
            end
            r0_pd     = (c == 0);
            r0_pd_num = (c == 0) ? 8'd20 : 8'd0;
            next_cycle();
        end
    endtask

    task automatic test_cr_en_hold();
        do_reset();
        cr_en = 1'b0;
        for (int c = 0; c < 17; c++) begin
            checks++;
            if (ph_cr !== (c >= 11 && c <= 13)) begin
                errors++;
                $display("FAIL cr_en_hold cycle %0d: ph_cr=%b want %b", c, ph_cr, (c >= 11 && c <= 13));
            end
            r1_ph = (c < 3);
            cr_en = (c >= 10);
            next_cycle();
        end
    endtask

    task automatic test_saturate();
        int n_s, n_m;
        do_reset();
        cr_en = 1'b0;
        for (int c = 0; c < 17; c++) begin
            r0_npd = 1'b1;
            next_cycle();
        end
        r0_npd = 1'b0;
        checks++;
        if ({overflow_s, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL sat_flag: overflow_small/main=%b want 10", {overflow_s, overflow});
        end
        cr_en = 1'b1;
        n_s = 0;
        n_m = 0;
        for (int c = 0; c < 25; c++) begin
            next_cycle();
            n_s += int'(npd_cr_s);
            n_m += int'(npd_cr);
        end
        checks++;
        if (n_s != 15) begin
            errors++;
            $display("FAIL sat_drain_small: pulses=%0d want 15", n_s);
        end
        checks++;
        if (n_m != 17) begin
            errors++;
            $display("FAIL sat_drain_main: pulses=%0d want 17", n_m);
        end
        checks++;
        if ({overflow_s, pend_empty_s} !== 2'b11) begin
            errors++;
            $display("FAIL sat_sticky: overflow/pend_empty=%b want 11", {overflow_s, pend_empty_s});
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic all_empty;
        do_reset();
        r0_pd = 1'b1; r0_pd_num = 8'd20; r0_ph = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        checks++;
        if ({pd_cr, pd_num, ph_cr} !== {1'b1, 8'd8, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre: pd_cr=%b pd_num=%0d ph_cr=%b want 1/8/1", pd_cr, pd_num, ph_cr);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({ph_cr, nph_cr, npd_cr, pd_cr, pd_num, overflow, pend_empty} !== 14'b0000_00000000_01) begin
            errors++;
            $display("FAIL mid_async: got %b want 00000000000001",
                     {ph_cr, nph_cr, npd_cr, pd_cr, pd_num, overflow, pend_empty});
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        all_empty = 1'b1;
        for (int c = 0; c < 25; c++) begin
            next_cycle();
            pulses += int'(ph_cr) + int'(pd_cr) + int'(nph_cr) + int'(npd_cr);
            all_empty &= pend_empty;
        end
        checks++;
        if (pulses != 0 || all_empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: pulses=%0d empty=%b want 0/1", pulses, all_empty);
        end
    endtask

    task automatic test_random();
        logic [13:0] got, want;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            got  = {ph_cr, nph_cr, npd_cr, pd_cr, pd_num, overflow, pend_empty};
            want = {e_ph, e_nph, e_npd, e_pd, 8'(e_num), m_ovf, e_empty};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", c, got, want);
            end
            r0_ph  = ($urandom_range(0, 3) == 0);
            r0_nph = ($urandom_range(0, 3) == 0);
            r0_npd = ($urandom_range(0, 4) == 0);
            r1_ph  = ($urandom_range(0, 4) == 0);
            r1_nph = ($urandom_range(0, 5) == 0);
            r1_npd = ($urandom_range(0, 3) == 0);
            r0_pd  = ($urandom_range(0, 7) == 0);
            r1_pd  = ($urandom_range(0, 9) == 0);
            r0_pd_num = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 60)) : 8'($urandom_range(0, 6));
            r1_pd_num = 8'($urandom_range(0, 12));
            cr_en  = (c % 200 < 150) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            next_cycle();
        end
    endtask

    initial begin
        rstn = 1'b0;
        cr_en = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_ph_single();
        test_nph_dual();
        test_pd_burst();
        test_cr_en_hold();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
